// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// address field geometry and the miss-handling state encoding.
package dcache_pkg;

  localparam int INDEX_BITS  = 4;
  localparam int OFFSET_BITS = 2;
  localparam int ADDR_WIDTH  = 32;
  localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS - 2;

  // Bit positions of the fields inside a byte address.
  localparam int OFFSET_LSB = 2;
  localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_BITS;
  localparam int TAG_LSB    = INDEX_LSB + INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB     = 2'd1,
    ST_REFILL = 2'd2
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty bits (reset), tags and data words (not reset).
// Reads are combinational; all writes land on the rising clock edge.
module dcache_array #(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_BITS    = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_BITS-1:0]  index,
  input  logic [OFFSET_BITS-1:0] rd_offset,
  input  logic [OFFSET_BITS-1:0] wb_offset,
  output logic                   line_valid,
  output logic                   line_dirty,
  output logic [TAG_BITS-1:0]    line_tag,
  output logic [31:0]            rd_word,
  output logic [31:0]            wb_word,
  input  logic                   store_en,
  input  logic [31:0]            store_data,
  input  logic                   refill_en,
  input  logic [OFFSET_BITS-1:0] refill_offset,
  input  logic [31:0]            refill_data,
  input  logic                   fill_en,
  input  logic [TAG_BITS-1:0]    fill_tag
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;

  logic [LINES-1:0]    valid;
  logic [LINES-1:0]    dirty;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0]         data [LINES][WORDS];

  assign line_valid = valid[index];
  assign line_dirty = dirty[index];
  assign line_tag   = tags[index];
  assign rd_word    = data[index][rd_offset];
  assign wb_word    = data[index][wb_offset];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (store_en) dirty[index] <= 1'b1;
      if (fill_en) begin
        valid[index] <= 1'b1;
        dirty[index] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store_en)  data[index][rd_offset]     <= store_data;
    if (refill_en) data[index][refill_offset] <= refill_data;
    if (fill_en)   tags[index]                <= fill_tag;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data cache controller: zero-latency hits, and on a miss an
// optional 4-beat writeback of the dirty victim followed by a 4-beat refill.
module dcache_ctrl #(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic                  MemtoRegM,
  input  logic                  MemWriteM,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [31:0]           WriteDataM,
  output logic [31:0]           ReadDataM,
  output logic                  cache_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output dcache_pkg::state_t    state_dbg
);
  import dcache_pkg::*;

  localparam int TB = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS - 2;
  localparam int IL = 2 + OFFSET_BITS;
  localparam int TL = IL + INDEX_BITS;

  // Beat handshake: mem_req/mem_we/mem_addr/mem_wdata are held until the
  // cycle mem_ack is sampled high; that edge retires the beat.
  state_t                 state;
  logic [OFFSET_BITS-1:0] beat;
  logic [OFFSET_BITS-1:0] beat_next;
  logic [INDEX_BITS-1:0]  miss_index;
  logic [TB-1:0]          miss_tag;
  logic [TB-1:0]          victim_tag;

  logic                   access;
  logic [OFFSET_BITS-1:0] req_offset;
  logic [INDEX_BITS-1:0]  req_index;
  logic [TB-1:0]          req_tag;
  logic [INDEX_BITS-1:0]  arr_index;
  logic [OFFSET_BITS-1:0] wb_offset;
  logic                   line_valid, line_dirty, hit;
  logic [TB-1:0]          line_tag;
  logic [31:0]            wb_word;
  logic                   store_en, refill_en, fill_en;
  logic                   unused_byte_bits;

  assign access     = MemtoRegM | MemWriteM;
  assign req_offset = ALUResultM[2 +: OFFSET_BITS];
  assign req_index  = ALUResultM[IL +: INDEX_BITS];
  assign req_tag    = ALUResultM[ADDR_WIDTH-1:TL];
  assign unused_byte_bits = ^ALUResultM[1:0];

  assign beat_next = beat + OFFSET_BITS'(1);
  // While a miss is in flight the array is addressed by the latched line.
  assign arr_index = (state == ST_IDLE) ? req_index : miss_index;
  assign wb_offset = (state == ST_IDLE) ? '0 : beat_next;

  assign hit         = line_valid & (line_tag == req_tag);
  assign cache_ready = ~access | ((state == ST_IDLE) & hit);
  assign store_en    = (state == ST_IDLE) & MemWriteM & hit;
  assign refill_en   = (state == ST_REFILL) & mem_ack;
  assign fill_en     = refill_en & (&beat);
  assign state_dbg   = state;

  function automatic logic [ADDR_WIDTH-1:0] beat_addr(
    input logic [TB-1:0] tag, input logic [INDEX_BITS-1:0] idx,
    input logic [OFFSET_BITS-1:0] off);
    beat_addr = {tag, idx, off, 2'b00};
  endfunction

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .OFFSET_BITS(OFFSET_BITS),
    .TAG_BITS   (TB)
  ) u_array (
    .clk          (CLK),
    .rst_n        (Reset_n),
    .index        (arr_index),
    .rd_offset    (req_offset),
    .wb_offset    (wb_offset),
    .line_valid   (line_valid),
    .line_dirty   (line_dirty),
    .line_tag     (line_tag),
    .rd_word      (ReadDataM),
    .wb_word      (wb_word),
    .store_en     (store_en),
    .store_data   (WriteDataM),
    .refill_en    (refill_en),
    .refill_offset(beat),
    .refill_data  (mem_rdata),
    .fill_en      (fill_en),
    .fill_tag     (miss_tag)
  );

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state      <= ST_IDLE;
      beat       <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            if (hit) begin
              hit_count <= hit_count + 32'd1;
            end else begin
              miss_count <= miss_count + 32'd1;
              miss_index <= req_index;
              miss_tag   <= req_tag;
              victim_tag <= line_tag;
              beat       <= '0;
              mem_req    <= 1'b1;
              if (line_valid & line_dirty) begin
                state     <= ST_WB;
                mem_we    <= 1'b1;
                mem_addr  <= beat_addr(line_tag, req_index, '0);
                mem_wdata <= wb_word;
              end else begin
                state    <= ST_REFILL;
                mem_we   <= 1'b0;
                mem_addr <= beat_addr(req_tag, req_index, '0);
              end
            end
          end
        end
        ST_WB: begin
          if (mem_ack) begin
            beat <= beat_next;
            if (&beat) begin
              state    <= ST_REFILL;
              mem_we   <= 1'b0;
              mem_addr <= beat_addr(miss_tag, miss_index, '0);
            end else begin
              mem_addr  <= beat_addr(victim_tag, miss_index, beat_next);
              mem_wdata <= wb_word;
            end
          end
        end
        ST_REFILL: begin
          if (mem_ack) begin
            beat <= beat_next;
            if (&beat) begin
              state   <= ST_IDLE;
              mem_req <= 1'b0;
            end else begin
              mem_addr <= beat_addr(miss_tag, miss_index, beat_next);
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboarded bench for dcache_ctrl: a memory responder with varying ack
// delays checks every beat against an expected queue, a monitor checks loads.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic        MemtoRegM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        cache_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] hit_count, miss_count;
  state_t      state_dbg;

  dcache_ctrl dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .cache_ready(cache_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .state_dbg  (state_dbg)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [64:0] exp_q[$];     // {we, addr, wdata} per expected beat
  logic [31:0] exp_ld_q[$];
  logic [31:0] mem_model [256];
  int          ack_budget = -1;
  int          delay_tab [6] = '{0, 1, 3, 5, 2, 4};
  int          delay_idx = 0;
  int          wait_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_refill(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, base + 32'(4 * i), 32'h0});
  endtask

  task automatic access(input logic ld, input logic [31:0] addr, input logic [31:0] wd,
                        output int waits);
    @(posedge CLK); #1;
    MemtoRegM = ld; MemWriteM = !ld; ALUResultM = addr; WriteDataM = wd;
    waits = 0;
    @(negedge CLK);
    while (!cache_ready && waits < 300) begin
      waits++;
      @(negedge CLK);
    end
    if (!cache_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL access_timeout: addr %h still not ready after %0d cycles", addr, waits);
    end
    @(posedge CLK); #1;
    MemtoRegM = 1'b0; MemWriteM = 1'b0;
  endtask

  // Memory responder: acks after a per-beat delay and scoreboards each beat.
  initial begin
    logic [64:0] e;
    forever begin
      @(posedge CLK); #2;
      if (Reset_n && mem_req && ack_budget != 0) begin
        if (wait_cnt < delay_tab[delay_idx]) begin
          mem_ack = 1'b0;
          wait_cnt++;
        end else begin
          mem_ack = 1'b1;
          wait_cnt = 0;
          delay_idx = (delay_idx + 1) % 6;
          if (ack_budget > 0) ack_budget--;
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL beat_unexpected: got addr %h we %b, expected no beat", mem_addr, mem_we);
          end else begin
            e = exp_q.pop_front();
            check("beat_we", 32'(mem_we), 32'(e[64]));
            check("beat_addr", mem_addr, e[63:32]);
            if (e[64]) check("beat_wdata", mem_wdata, e[31:0]);
          end
          if (mem_we) mem_model[mem_addr[9:2]] = mem_wdata;
          else        mem_rdata = mem_model[mem_addr[9:2]];
        end
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  // Beat outputs must not move while a request waits for its ack.
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  always @(negedge CLK) begin
    if (Reset_n && mem_req && prev_req && !prev_ack) begin
      check("hold_addr", mem_addr, prev_addr);
      check("hold_wdata", mem_wdata, prev_wdata);
      check("hold_we", 32'(mem_we), 32'(prev_we));
    end
    prev_req = mem_req && Reset_n; prev_ack = mem_ack; prev_we = mem_we;
    prev_addr = mem_addr; prev_wdata = mem_wdata;
  end

  always @(negedge CLK) begin
    if (Reset_n && cache_ready && MemtoRegM) begin
      if (exp_ld_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL load_unexpected: got %h, expected no load", ReadDataM);
      end else begin
        check("load_data", ReadDataM, exp_ld_q.pop_front());
      end
    end
  end

  always @(posedge CLK) begin
    assert (!(MemtoRegM && MemWriteM)) else $error("load and store asserted together");
  end

  initial begin
    int w;
    for (int i = 0; i < 256; i++) mem_model[i] = {16'hA5A5, 16'(i * 4 - 255)};

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_ready", 32'(cache_ready), 32'd1);
    @(posedge CLK); #1;
    Reset_n = 1'b1;

    // Cold load miss: refill 0x100..0x10C then hit
    push_refill(32'h100);
    exp_ld_q.push_back(32'hA5A5_0001);
    access(1'b1, 32'h100, 32'h0, w);
    check("cold_stalled", 32'(w >= 5), 32'd1);
    check("cold_beats_done", 32'(exp_q.size()), 32'd0);
    check("cold_misses", miss_count, 32'd1);
    check("cold_hits", hit_count, 32'd1);

    // Load hit in the same line
    exp_ld_q.push_back(32'hA5A5_0005);
    access(1'b1, 32'h104, 32'h0, w);
    check("hit104_waits", 32'(w), 32'd0);
    check("hit104_hits", hit_count, 32'd2);

    // Store hit then load back
    access(1'b0, 32'h108, 32'hDEAD_BEEF, w);
    check("store_waits", 32'(w), 32'd0);
    exp_ld_q.push_back(32'hDEAD_BEEF);
    access(1'b1, 32'h108, 32'h0, w);
    check("ld108_waits", 32'(w), 32'd0);
    check("ld108_hits", hit_count, 32'd4);
    check("ld108_misses", miss_count, 32'd1);

    // Conflict miss: dirty writeback of line 0x100 then refill of 0x200
    exp_q.push_back({1'b1, 32'h100, 32'hA5A5_0001});
    exp_q.push_back({1'b1, 32'h104, 32'hA5A5_0005});
    exp_q.push_back({1'b1, 32'h108, 32'hDEAD_BEEF});
    exp_q.push_back({1'b1, 32'h10C, 32'hA5A5_000D});
    push_refill(32'h200);
    exp_ld_q.push_back(32'hA5A5_0109);
    access(1'b1, 32'h208, 32'h0, w);
    check("conf_beats_done", 32'(exp_q.size()), 32'd0);
    check("conf_misses", miss_count, 32'd2);
    check("conf_hits", hit_count, 32'd5);
    check("wb_mem_word", mem_model[32'h108 >> 2], 32'hDEAD_BEEF);

    // Reset during the second refill beat aborts the miss
    ack_budget = 1;
    exp_q.push_back({1'b0, 32'h300, 32'h0});
    @(posedge CLK); #1;
    MemtoRegM = 1'b1; ALUResultM = 32'h300;
    w = 0;
    @(negedge CLK);
    while (!(mem_req && mem_addr == 32'h304) && w < 100) begin
      w++;
      @(negedge CLK);
    end
    check("abort_reached_beat2", 32'(mem_req && mem_addr == 32'h304), 32'd1);
    Reset_n = 1'b0;
    @(negedge CLK);
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    check("abort_hits", hit_count, 32'd0);
    check("abort_misses", miss_count, 32'd0);
    check("abort_beats", 32'(exp_q.size()), 32'd0);
    @(posedge CLK); #1;
    Reset_n = 1'b1;
    ack_budget = -1;
    push_refill(32'h300);
    exp_ld_q.push_back(32'hA5A5_0201);
    w = 0;
    @(negedge CLK);
    while (!cache_ready && w < 300) begin
      w++;
      @(negedge CLK);
    end
    check("retry_ready", 32'(cache_ready), 32'd1);
    @(posedge CLK); #1;
    MemtoRegM = 1'b0;
    @(negedge CLK);
    check("retry_misses", miss_count, 32'd1);
    check("retry_hits", hit_count, 32'd1);
    check("retry_beats_done", 32'(exp_q.size()), 32'd0);
    check("loads_done", 32'(exp_ld_q.size()), 32'd0);

    repeat (3) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache sitting in the MEM stage between the pipeline's load/store datapath and the word-wide external data memory. It serves LDR/STR issued in MEM and produces cache_ready, which the hazard unit uses to raise StallF/D/E/M on a read or write miss. On a miss it writes back the victim line if dirty, refills the line word by word over a req/ack handshake, then completes the access as a hit.

Parameters:
INDEX_BITS, 4, log2 number of lines (16 lines)
OFFSET_BITS, 2, log2 words per line (4 words, 16 B)
ADDR_WIDTH, 32, byte address width; tag = ADDR_WIDTH-INDEX_BITS-OFFSET_BITS-2 bits

Ports:
CLK  in  1  clock, rising edge
Reset_n  in  1  synchronous active-low reset
MemtoRegM  in  1  load in MEM
MemWriteM  in  1  store in MEM
ALUResultM  in  32  byte address; bits[1:0] ignored
WriteDataM  in  32  store data
ReadDataM  out  32  load data, valid when cache_ready=1 and MemtoRegM=1
cache_ready  out  1  access completes this cycle; to hazard unit
mem_req  out  1  memory beat request
mem_we  out  1  1=write beat (writeback), 0=read beat (refill)
mem_addr  out  32  word-aligned beat address
mem_wdata  out  32  writeback data
mem_ack  in  1  beat accepted/completed this cycle
mem_rdata  in  32  refill data, valid with mem_ack on read beat
hit_count  out  32  perf counter: completed hits
miss_count  out  32  perf counter: misses (counted on entering miss handling)

Behaviour:
- Address split: offset=addr[OFFSET_BITS+1:2], index=next INDEX_BITS, tag=remaining upper bits.
- Per line: valid, dirty, tag, data[4]. Reset clears all valid/dirty, state=IDLE, mem_req=0, counters=0; tag/data not reset. Reset mid-miss aborts: mem_req drops the following cycle, dirty data is lost by design.
- cache_ready (combinational) = ~(MemtoRegM|MemWriteM) | (state==IDLE & hit). hit = valid[index] & tag match.
- Hit latency 0: load data is read combinationally from the array in the same cycle; a store hit writes the word and sets dirty at the clock edge.
- States: IDLE, WB, REFILL.
  - IDLE: access & ~hit -> WB if victim valid&dirty, else REFILL; latch line base address; miss_count++.
  - WB: 4 write beats at {victim tag, index, beat}; after 4th ack -> REFILL.
  - REFILL: 4 read beats at {req tag, index, beat}; each ack writes mem_rdata into data[beat]; after 4th ack, set valid=1, dirty=0, tag=req tag -> IDLE; the access then hits next cycle.
- Beat handshake: mem_req, mem_we, mem_addr, mem_wdata stable until mem_ack; beat counter advances on ack; mem_req stays high between beats within a phase; deasserted in IDLE.
- Pipeline holds MEM inputs stable while cache_ready=0; no re-latching of request data is required beyond the line base.
- hit_count increments in each IDLE cycle with an access and hit (including the post-refill hit). Both counters wrap at 2^32.
- MemtoRegM & MemWriteM both high: illegal; treated as store; assertion in bench.
- No access (both low): cache_ready=1, ReadDataM = array word at current index/offset (don't care).

Decomposition:
- Shared package dcache_pkg: state encoding (IDLE/WB/REFILL), field width localparams, address-split helper constants.
- One sub-module: dcache_array (tag/valid/dirty/data storage; combinational read, synchronous write port for word store, refill word, and tag/valid/dirty update).

Test Plan:
- Cold load 0x0000_0100, memory word 0x100=0xA5A5_0001 -> cache_ready low for 4 acked read beats at 0x100,0x104,0x108,0x10C, then cache_ready=1, ReadDataM=0xA5A5_0001; miss_count=1, hit_count=1.
- Load 0x104 right after -> same-cycle cache_ready=1, correct data, no mem_req.
- Store 0xDEAD_BEEF to 0x108 (hit) then load 0x108 -> 0xDEAD_BEEF, line dirty, no memory traffic.
- Load conflicting 0x0000_0208 (same index, new tag) -> 4 write beats 0x100..0x10C with 0x108 carrying 0xDEAD_BEEF, then 4 read beats 0x200..0x20C, then hit.
- Insert mem_ack delays of 0-5 cycles per beat -> mem_addr/mem_wdata held stable while mem_req=1 and ack=0; beat order unchanged.
- Assert Reset_n=0 during 2nd refill beat -> next cycle mem_req=0, state IDLE, counters 0; repeat load misses again.
